// File: rtl/s298_bist_ctrl_if.sv
// Control/observe bundle between the s298 logic-BIST controller and the DFT wrapper.
// The slave side is the BIST controller; the master side is the wrapper driving start/abort and the core response.
interface s298_bist_ctrl_if;
  logic        start;
  logic        abort;
  logic [2:0]  tpg_out;
  logic [5:0]  cut_resp;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;
  logic [15:0] pat_cnt;

  modport master (
    output start, abort, cut_resp,
    input  tpg_out, busy, done, pass, signature, pat_cnt
  );

  modport slave (
    input  start, abort, cut_resp,
    output tpg_out, busy, done, pass, signature, pat_cnt
  );
endinterface

// File: rtl/s298_bist_ctrl.sv
// Logic-BIST controller for s298: LFSR pattern source on {G2,G1,G0}, 16-bit MISR
// compaction of the six core outputs, and done/pass reporting against a golden signature.
module s298_bist_ctrl #(
  parameter int unsigned PAT_COUNT   = 256,
  parameter int unsigned INIT_CYCLES = 2,
  parameter int unsigned RESP_LAT    = 1,
  parameter logic [7:0]  LFSR_SEED   = 8'h01,
  parameter logic [15:0] MISR_SEED   = 16'h0000,
  parameter logic [15:0] GOLDEN_SIG  = 16'h0000
) (
  input  logic                CK,
  input  logic                RST,
  s298_bist_ctrl_if.slave     bus
);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_FLUSH, S_DONE} state_t;

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [7:0] LFSR_LOAD = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [5:0] r);
    return ({m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000)) ^ {10'b0, r};
  endfunction

  state_t      state_q, state_d;
  logic [31:0] cyc_q, cyc_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [15:0] misr_q, misr_d;
  logic [15:0] pat_cnt_q, pat_cnt_d;
  logic [2:0]  tpg_q, tpg_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    lfsr_d    = lfsr_q;
    misr_d    = misr_q;
    pat_cnt_d = pat_cnt_q;

    case (state_q)
      S_INIT: begin
        if (cyc_q == INIT_CYCLES - 1) begin
          state_d = S_RUN;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 32'd1;
        end
      end
      S_RUN: begin
        lfsr_d    = lfsr_step(lfsr_q);
        pat_cnt_d = (pat_cnt_q == 16'hFFFF) ? pat_cnt_q : pat_cnt_q + 16'd1;
        // The first RESP_LAT responses belong to the INIT stimulus, not to a pattern.
        if (cyc_q >= RESP_LAT) misr_d = misr_step(misr_q, bus.cut_resp);
        if (cyc_q == PAT_COUNT - 1) begin
          state_d = (RESP_LAT == 0) ? S_DONE : S_FLUSH;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 32'd1;
        end
      end
      S_FLUSH: begin
        misr_d = misr_step(misr_q, bus.cut_resp);
        if (cyc_q == RESP_LAT - 1) begin
          state_d = S_DONE;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 32'd1;
        end
      end
      default: ;
    endcase

    // Abort freezes signature and pattern count at their partial values.
    if (bus.abort) begin
      if (state_q != S_IDLE) begin
        state_d   = S_IDLE;
        cyc_d     = '0;
        lfsr_d    = lfsr_q;
        misr_d    = misr_q;
        pat_cnt_d = pat_cnt_q;
      end
    end else if (bus.start && (state_q == S_IDLE || state_q == S_DONE)) begin
      state_d   = (INIT_CYCLES == 0) ? S_RUN : S_INIT;
      cyc_d     = '0;
      lfsr_d    = LFSR_LOAD;
      misr_d    = MISR_SEED;
      pat_cnt_d = '0;
    end

    // Outputs are decoded from the next state so they are registered yet cycle-aligned.
    tpg_d  = (state_d == S_INIT) ? 3'b001 : (state_d == S_RUN) ? lfsr_d[2:0] : 3'b000;
    busy_d = (state_d == S_INIT) || (state_d == S_RUN) || (state_d == S_FLUSH);
    done_d = (state_d == S_DONE);
    pass_d = 1'b0;
    if (state_d == S_DONE) pass_d = (state_q == S_DONE) ? pass_q : (misr_d == GOLDEN_SIG);
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cyc_q     <= '0;
      lfsr_q    <= LFSR_LOAD;
      misr_q    <= '0;
      pat_cnt_q <= '0;
      tpg_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      lfsr_q    <= lfsr_d;
      misr_q    <= misr_d;
      pat_cnt_q <= pat_cnt_d;
      tpg_q     <= tpg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  assign bus.tpg_out   = tpg_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.signature = misr_q;
  assign bus.pat_cnt   = pat_cnt_q;

endmodule

// File: tb/tb_s298_bist_ctrl.sv
// Bench for s298_bist_ctrl: three controller instances with different parameter sets,
// each driving a small behavioural stand-in core, checked against a pattern/signature model.
module tb_s298_bist_ctrl;

  logic CK;
  logic RST;
  int   errors;
  int   checks;

  s298_bist_ctrl_if ifa ();
  s298_bist_ctrl_if ifb ();
  s298_bist_ctrl_if ifc ();

  s298_bist_ctrl #(
    .PAT_COUNT(256), .INIT_CYCLES(2), .RESP_LAT(1),
    .LFSR_SEED(8'h01), .MISR_SEED(16'h0000), .GOLDEN_SIG(16'h0000)
  ) u_a (.CK(CK), .RST(RST), .bus(ifa));

  s298_bist_ctrl #(
    .PAT_COUNT(2), .INIT_CYCLES(2), .RESP_LAT(1),
    .LFSR_SEED(8'h01), .MISR_SEED(16'h0000), .GOLDEN_SIG(16'h0003)
  ) u_b (.CK(CK), .RST(RST), .bus(ifb));

  s298_bist_ctrl #(
    .PAT_COUNT(20), .INIT_CYCLES(3), .RESP_LAT(2),
    .LFSR_SEED(8'h00), .MISR_SEED(16'hACE1), .GOLDEN_SIG(16'h0000)
  ) u_c (.CK(CK), .RST(RST), .bus(ifc));

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  // Stand-in core: a nonlinear 3->6 mapping keyed per run, with optional G66 stuck-at-0.
  function automatic logic [5:0] core_f(input logic [2:0] p, input logic [5:0] key, input bit fault);
    logic [5:0] r;
    r = {p[0] & p[1], p[2] | p[0], p[1] ^ p[2], p} ^ key;
    if (fault) r[0] = 1'b0;
    return r;
  endfunction

  logic [5:0] key_a, key_c, resp_b;
  bit         fault_a, fault_c;
  logic [2:0] pipe_a, pipe_c0, pipe_c1;

  always @(posedge CK) begin
    pipe_a  <= ifa.tpg_out;
    pipe_c0 <= ifc.tpg_out;
    pipe_c1 <= pipe_c0;
  end

  assign ifa.cut_resp = core_f(pipe_a, key_a, fault_a);
  assign ifb.cut_resp = resp_b;
  assign ifc.cut_resp = core_f(pipe_c1, key_c, fault_c);

  // Reference: the n patterns a run applies, and the signature of their responses in order.
  logic [7:0] mpat [0:255];

  task automatic run_model(input int n, input logic [7:0] seed, input logic [15:0] mseed,
                           input logic [5:0] key, input bit fault, output logic [15:0] sig);
    logic [7:0] l;
    l   = (seed == 8'h00) ? 8'h01 : seed;
    sig = mseed;
    for (int k = 0; k < n; k++) begin
      mpat[k] = l;
      sig = {sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000) ^ {10'b0, core_f(l[2:0], key, fault)};
      l = {l[6:0], ^(l & 8'hB8)};
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    ifa.start = 1'b1; ifb.start = 1'b1; ifc.start = 1'b1;
    tick(); tick();
    checks++; if (ifa.tpg_out !== 3'b000) begin errors++; $display("FAIL reset_tpg got=%b want=000", ifa.tpg_out); end
    checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", ifa.busy); end
    checks++; if (ifa.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", ifa.done); end
    checks++; if (ifa.pass !== 1'b0) begin errors++; $display("FAIL reset_pass got=%b want=0", ifa.pass); end
    checks++; if (ifa.signature !== 16'h0000) begin errors++; $display("FAIL reset_sig got=%h want=0000", ifa.signature); end
    checks++; if (ifa.pat_cnt !== 16'h0000) begin errors++; $display("FAIL reset_patcnt got=%h want=0000", ifa.pat_cnt); end
    checks++; if (ifc.signature !== 16'h0000) begin errors++; $display("FAIL reset_sig_c got=%h want=0000", ifc.signature); end
    ifa.start = 1'b0; ifb.start = 1'b0; ifc.start = 1'b0;
    RST = 1'b0;
    tick();
    checks++; if (ifb.busy !== 1'b0) begin errors++; $display("FAIL reset_idle_b got=%b want=0", ifb.busy); end
  endtask

  task automatic test_lfsr();
    logic [2:0]  lit [0:4];
    logic [2:0]  exp_t;
    logic [15:0] msig;
    int n;
    lit[0] = 3'b001; lit[1] = 3'b010; lit[2] = 3'b100; lit[3] = 3'b000; lit[4] = 3'b001;
    key_a = 6'($urandom); fault_a = 0;
    run_model(256, 8'h01, 16'h0000, key_a, 0, msig);
    ifa.start = 1'b1; tick(); ifa.start = 1'b0;
    checks++; if (ifa.busy !== 1'b1) begin errors++; $display("FAIL lfsr_busy got=%b want=1", ifa.busy); end
    for (int i = 0; i < 12; i++) begin
      if (i < 2) exp_t = 3'b001;
      else if (i < 7) exp_t = lit[i-2];
      else exp_t = mpat[i-2][2:0];
      checks++;
      if (ifa.tpg_out !== exp_t) begin errors++; $display("FAIL lfsr_tpg[%0d] got=%b want=%b", i, ifa.tpg_out, exp_t); end
      tick();
    end
    n = 0;
    while (!ifa.done && n < 400) begin tick(); n++; end
    checks++; if (ifa.done !== 1'b1) begin errors++; $display("FAIL lfsr_done_timeout got=%b want=1", ifa.done); end
    checks++; if (ifa.signature !== msig) begin errors++; $display("FAIL lfsr_sig got=%h want=%h", ifa.signature, msig); end
    checks++; if (ifa.pass !== (msig == 16'h0000)) begin errors++; $display("FAIL lfsr_pass got=%b want=%b", ifa.pass, msig == 16'h0000); end
    checks++; if (ifa.pat_cnt !== 16'd256) begin errors++; $display("FAIL lfsr_patcnt got=%0d want=256", ifa.pat_cnt); end
    checks++; if (ifa.busy !== 1'b0 || ifa.tpg_out !== 3'b000) begin errors++; $display("FAIL lfsr_done_outs busy=%b tpg=%b want 0/000", ifa.busy, ifa.tpg_out); end
  endtask

  task automatic test_misr();
    int e;
    resp_b = 6'h01;
    ifb.start = 1'b1; tick(); ifb.start = 1'b0;
    e = 1;
    while (!ifb.done && e < 50) begin tick(); e++; end
    checks++; if (e != 6 || ifb.done !== 1'b1) begin errors++; $display("FAIL misr_latency got=%0d edges want=6", e); end
    checks++; if (ifb.signature !== 16'h0003) begin errors++; $display("FAIL misr_sig got=%h want=0003", ifb.signature); end
    checks++; if (ifb.pass !== 1'b1) begin errors++; $display("FAIL misr_pass got=%b want=1", ifb.pass); end
    checks++; if (ifb.pat_cnt !== 16'd2) begin errors++; $display("FAIL misr_patcnt got=%0d want=2", ifb.pat_cnt); end
    tick(); tick();
    checks++; if (ifb.done !== 1'b1 || ifb.signature !== 16'h0003) begin errors++; $display("FAIL misr_hold done=%b sig=%h want 1/0003", ifb.done, ifb.signature); end
    resp_b = 6'h00;
    ifb.start = 1'b1; tick(); ifb.start = 1'b0;
    checks++; if (ifb.done !== 1'b0 || ifb.busy !== 1'b1) begin errors++; $display("FAIL misr_restart done=%b busy=%b want 0/1", ifb.done, ifb.busy); end
    e = 1;
    while (!ifb.done && e < 50) begin tick(); e++; end
    checks++; if (e != 6) begin errors++; $display("FAIL misr_latency0 got=%0d edges want=6", e); end
    checks++; if (ifb.signature !== 16'h0000) begin errors++; $display("FAIL misr_sig0 got=%h want=0000", ifb.signature); end
    checks++; if (ifb.pass !== 1'b0) begin errors++; $display("FAIL misr_pass0 got=%b want=0", ifb.pass); end
  endtask

  task automatic test_golden();
    logic [15:0] good, bad, msig;
    int n;
    for (int r = 0; r < 3; r++) begin
      if (r < 2) begin
        key_a = 6'($urandom); fault_a = 0;
        run_model(256, 8'h01, 16'h0000, key_a, 0, msig);
      end else begin
        for (int t = 0; t < 16; t++) begin
          key_a = 6'($urandom);
          run_model(256, 8'h01, 16'h0000, key_a, 0, good);
          run_model(256, 8'h01, 16'h0000, key_a, 1, bad);
          if (good != bad) break;
        end
        fault_a = 1;
        msig = bad;
      end
      ifa.start = 1'b1; tick(); ifa.start = 1'b0;
      n = 0;
      while (!ifa.done && n < 400) begin tick(); n++; end
      checks++; if (ifa.done !== 1'b1) begin errors++; $display("FAIL golden_timeout run=%0d got=%b want=1", r, ifa.done); end
      checks++; if (ifa.signature !== msig) begin errors++; $display("FAIL golden_sig run=%0d got=%h want=%h", r, ifa.signature, msig); end
      checks++; if (ifa.pass !== (msig == 16'h0000)) begin errors++; $display("FAIL golden_pass run=%0d got=%b want=%b", r, ifa.pass, msig == 16'h0000); end
    end
    checks++; if (ifa.signature === good) begin errors++; $display("FAIL golden_fault_detect got=%h want!=%h", ifa.signature, good); end
    fault_a = 0;
  endtask

  task automatic test_abort();
    logic [15:0] part, full;
    int n;
    key_a = 6'($urandom); fault_a = 0;
    run_model(9, 8'h01, 16'h0000, key_a, 0, part);
    run_model(256, 8'h01, 16'h0000, key_a, 0, full);
    ifa.start = 1'b1; tick(); ifa.start = 1'b0;
    n = 0;
    while (ifa.pat_cnt != 16'd10 && n < 100) begin tick(); n++; end
    ifa.abort = 1'b1; tick(); ifa.abort = 1'b0;
    checks++; if (ifa.busy !== 1'b0 || ifa.done !== 1'b0 || ifa.pass !== 1'b0) begin errors++; $display("FAIL abort_flags busy=%b done=%b pass=%b want 0/0/0", ifa.busy, ifa.done, ifa.pass); end
    checks++; if (ifa.tpg_out !== 3'b000) begin errors++; $display("FAIL abort_tpg got=%b want=000", ifa.tpg_out); end
    checks++; if (ifa.pat_cnt !== 16'd10) begin errors++; $display("FAIL abort_patcnt got=%0d want=10", ifa.pat_cnt); end
    checks++; if (ifa.signature !== part) begin errors++; $display("FAIL abort_sig got=%h want=%h", ifa.signature, part); end
    tick(); tick(); tick();
    checks++; if (ifa.pat_cnt !== 16'd10 || ifa.busy !== 1'b0) begin errors++; $display("FAIL abort_hold patcnt=%0d busy=%b want 10/0", ifa.pat_cnt, ifa.busy); end
    ifa.start = 1'b1; tick(); ifa.start = 1'b0;
    n = 0;
    while (!ifa.done && n < 400) begin tick(); n++; end
    checks++; if (ifa.signature !== full || ifa.done !== 1'b1) begin errors++; $display("FAIL abort_rerun_sig got=%h want=%h", ifa.signature, full); end
    checks++; if (ifa.pat_cnt !== 16'd256) begin errors++; $display("FAIL abort_rerun_patcnt got=%0d want=256", ifa.pat_cnt); end
  endtask

  task automatic test_rst_flush();
    logic [15:0] msig;
    int e;
    key_c = 6'($urandom); fault_c = 0;
    ifc.start = 1'b1; tick(); ifc.start = 1'b0;
    for (int i = 0; i < 23; i++) tick();
    checks++; if (ifc.busy !== 1'b1 || ifc.pat_cnt !== 16'd20) begin errors++; $display("FAIL flush_state busy=%b patcnt=%0d want 1/20", ifc.busy, ifc.pat_cnt); end
    RST = 1'b1; tick(); RST = 1'b0;
    checks++; if (ifc.busy !== 1'b0 || ifc.done !== 1'b0 || ifc.pass !== 1'b0 || ifc.tpg_out !== 3'b000) begin
      errors++; $display("FAIL rst_flush_flags busy=%b done=%b pass=%b tpg=%b want 0", ifc.busy, ifc.done, ifc.pass, ifc.tpg_out); end
    checks++; if (ifc.signature !== 16'h0000 || ifc.pat_cnt !== 16'h0000) begin errors++; $display("FAIL rst_flush_data sig=%h patcnt=%h want 0", ifc.signature, ifc.pat_cnt); end
    ifc.start = 1'b1; ifc.abort = 1'b1; tick(); ifc.start = 1'b0; ifc.abort = 1'b0;
    tick();
    checks++; if (ifc.busy !== 1'b0 || ifc.tpg_out !== 3'b000) begin errors++; $display("FAIL start_abort_idle busy=%b tpg=%b want 0/000", ifc.busy, ifc.tpg_out); end
    run_model(20, 8'h01, 16'hACE1, key_c, 0, msig);
    ifc.start = 1'b1; tick(); ifc.start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    ifc.start = 1'b1; tick(); ifc.start = 1'b0;
    checks++; if (ifc.pat_cnt !== 16'd3 || ifc.busy !== 1'b1) begin errors++; $display("FAIL start_busy_ignored patcnt=%0d busy=%b want 3/1", ifc.pat_cnt, ifc.busy); end
    e = 7;
    while (!ifc.done && e < 200) begin tick(); e++; end
    checks++; if (e != 26) begin errors++; $display("FAIL start_busy_latency got=%0d edges want=26", e); end
    checks++; if (ifc.signature !== msig) begin errors++; $display("FAIL start_busy_sig got=%h want=%h", ifc.signature, msig); end
  endtask

  task automatic test_seed0();
    logic [15:0] msig;
    logic [2:0]  exp_t;
    int e;
    for (int r = 0; r < 2; r++) begin
      key_c = 6'($urandom); fault_c = (r == 1);
      run_model(20, 8'h01, 16'hACE1, key_c, fault_c, msig);
      ifc.start = 1'b1; tick(); ifc.start = 1'b0;
      e = 1;
      for (int i = 0; i < 10; i++) begin
        exp_t = (i < 3) ? 3'b001 : mpat[i-3][2:0];
        checks++;
        if (ifc.tpg_out !== exp_t) begin errors++; $display("FAIL seed0_tpg run=%0d [%0d] got=%b want=%b", r, i, ifc.tpg_out, exp_t); end
        tick(); e++;
      end
      while (!ifc.done && e < 200) begin tick(); e++; end
      checks++; if (e != 26) begin errors++; $display("FAIL seed0_latency run=%0d got=%0d edges want=26", r, e); end
      checks++; if (ifc.signature !== msig) begin errors++; $display("FAIL seed0_sig run=%0d got=%h want=%h", r, ifc.signature, msig); end
      checks++; if (ifc.pass !== (msig == 16'h0000)) begin errors++; $display("FAIL seed0_pass run=%0d got=%b want=%b", r, ifc.pass, msig == 16'h0000); end
    end
    fault_c = 0;
  endtask

  initial begin
    errors = 0; checks = 0;
    RST = 1'b1;
    ifa.start = 1'b0; ifa.abort = 1'b0;
    ifb.start = 1'b0; ifb.abort = 1'b0;
    ifc.start = 1'b0; ifc.abort = 1'b0;
    key_a = '0; key_c = '0; resp_b = '0; fault_a = 0; fault_c = 0;
    test_reset();
    test_lfsr();
    test_misr();
    test_golden();
    test_abort();
    test_rst_flush();
    test_seed0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
